// File: rtl/imem_pkg.sv
// Shared constants, instruction field positions and FSM state type for the
// synchronous instruction memory.
package imem_pkg;

  localparam logic [31:0] NOOP = 32'h0000_0000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS_MSB  = 20;
  localparam int RS_LSB  = 16;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  // Assembles an instruction word from its fields; the low half is the immediate.
  function automatic logic [31:0] mkInstr(input logic [5:0] opc, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [15:0] imm);
    logic [31:0] w_word;
    w_word = NOOP;
    w_word[OPC_MSB:OPC_LSB] = opc;
    w_word[RD_MSB:RD_LSB]   = rd;
    w_word[RS_MSB:RS_LSB]   = rs;
    w_word[15:0]            = imm;
    return w_word;
  endfunction

endpackage

// File: rtl/instr_mem_sync_if.sv
// Fetch handshake bundle between a core (master) and the instruction memory (slave).
interface instr_mem_sync_if #(
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ready;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_out;
  logic              addr_err;
  logic              instr_ack;

  modport master (
    output fetch_req, fetch_addr, instr_ack,
    input  fetch_ready, instr_valid, instr_out, addr_err
  );

  modport slave (
    input  fetch_req, fetch_addr, instr_ack,
    output fetch_ready, instr_valid, instr_out, addr_err
  );
endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage, one synchronous write port and one registered read
// port; a same-edge read of the written index returns the old word.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Clear takes priority so a rejected fetch presents NOOP without touching the array.
  always_ff @(posedge clk) begin
    if (i_clr)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_sync.sv
// Clocked instruction memory: fetch FSM, address range/alignment check,
// optional second latency stage and a run-time program load port.
module instr_mem_sync
  import imem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter bit BYTE_ADDR = 1'b1,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  instr_mem_sync_if.slave   bus,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data
);

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_err;
  logic [ADDR_W-1:0] w_idx;
  logic [DATA_W-1:0] w_rdata;
  logic              r_err1;

  always_comb begin
    w_idx = '0;
    w_err = 1'b0;
    if (BYTE_ADDR) begin
      w_idx = bus.fetch_addr[ADDR_W+1:2];
      w_err = (bus.fetch_addr[1:0] != 2'b00) || ((bus.fetch_addr >> (ADDR_W + 2)) != 32'd0);
    end else begin
      w_idx = bus.fetch_addr[ADDR_W-1:0];
      w_err = (bus.fetch_addr >> ADDR_W) != 32'd0;
    end
  end

  assign w_accept = bus.fetch_req && (r_state == IDLE);

  imem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .i_we    (i_load_en && !rst),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_re    (w_accept && !w_err && !rst),
    .i_clr   (rst || (w_accept && w_err)),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.fetch_req) w_next = (READ_LAT == 1) ? HOLD : WAIT;
      WAIT:    w_next = HOLD;
      HOLD:    if (bus.instr_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           r_err1 <= 1'b0;
    else if (w_accept) r_err1 <= w_err;
  end

  assign bus.fetch_ready = (r_state == IDLE);
  assign bus.instr_valid = (r_state == HOLD);

  // The extra stage only re-times the result captured at acceptance.
  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] r_data2;
    logic              r_err2;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data2 <= '0;
        r_err2  <= 1'b0;
      end else if (r_state == WAIT) begin
        r_data2 <= w_rdata;
        r_err2  <= r_err1;
      end
    end

    assign bus.instr_out = r_data2;
    assign bus.addr_err  = r_err2;
  end else begin : g_lat1
    assign bus.instr_out = w_rdata;
    assign bus.addr_err  = r_err1;
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench driving a READ_LAT=1 instance (index 0) and a READ_LAT=2
// instance (index 1) side by side from a shared clock, reset and load port.
module tb_instr_mem_sync;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        loadEn;
  logic [7:0]  loadAddr;
  logic [31:0] loadData;

  logic        req   [2];
  logic [31:0] addr  [2];
  logic        ack   [2];
  logic        ready [2];
  logic        valid [2];
  logic        err   [2];
  logic [31:0] dout  [2];

  logic [31:0] prog [23];
  logic [31:0] held;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_mem_sync_if #(.DATA_W(32)) bus0 ();
  instr_mem_sync_if #(.DATA_W(32)) bus1 ();

  assign bus0.fetch_req  = req[0];
  assign bus0.fetch_addr = addr[0];
  assign bus0.instr_ack  = ack[0];
  assign bus1.fetch_req  = req[1];
  assign bus1.fetch_addr = addr[1];
  assign bus1.instr_ack  = ack[1];
  assign ready[0] = bus0.fetch_ready;
  assign valid[0] = bus0.instr_valid;
  assign err[0]   = bus0.addr_err;
  assign dout[0]  = bus0.instr_out;
  assign ready[1] = bus1.fetch_ready;
  assign valid[1] = bus1.instr_valid;
  assign err[1]   = bus1.addr_err;
  assign dout[1]  = bus1.instr_out;

  instr_mem_sync #(.DATA_W(32), .DEPTH(256), .BYTE_ADDR(1'b1), .READ_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .i_load_en(loadEn), .i_load_addr(loadAddr), .i_load_data(loadData)
  );

  instr_mem_sync #(.DATA_W(32), .DEPTH(256), .BYTE_ADDR(1'b1), .READ_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .i_load_en(loadEn), .i_load_addr(loadAddr), .i_load_data(loadData)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int d, input logic r, input logic [31:0] a, input logic k);
    req[d]  = r;
    addr[d] = a;
    ack[d]  = k;
  endtask

  task automatic loadWord(input logic [7:0] idx, input logic [31:0] data);
    loadEn = 1'b1; loadAddr = idx; loadData = data;
    tick;
    loadEn = 1'b0;
  endtask

  // One fetch with ack held high: checks latency, result and the return of fetch_ready.
  task automatic doFetch(input int d, input logic [31:0] a, input logic [31:0] expData,
                         input logic expErr, input string tag);
    int lat = d + 1;
    checkOutput({tag, ".ready"}, 32'(ready[d]), 32'd1);
    applyStimulus(d, 1'b1, a, 1'b1);
    tick;
    applyStimulus(d, 1'b0, 32'd0, 1'b1);
    for (int i = 1; i < lat; i++) begin
      checkOutput({tag, ".wait"}, 32'(valid[d]), 32'd0);
      tick;
    end
    checkOutput({tag, ".valid"}, 32'(valid[d]), 32'd1);
    checkOutput({tag, ".data"},  dout[d], expData);
    checkOutput({tag, ".err"},   32'(err[d]), 32'(expErr));
    checkOutput({tag, ".busy"},  32'(ready[d]), 32'd0);
    tick;
    checkOutput({tag, ".done"},  32'(valid[d]), 32'd0);
    checkOutput({tag, ".rdy2"},  32'(ready[d]), 32'd1);
  endtask

  initial begin
    // Synthetic 23-word program image: distinct, non-zero words.
    for (int i = 0; i < 23; i++)
      prog[i] = mkInstr(6'(i + 1), 5'(i), 5'(22 - i), 16'(16'hA000 + i));

    rst = 1'b1; loadEn = 1'b0; loadAddr = '0; loadData = '0;
    for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, 32'd0, 1'b0);
    tick;
    tick;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset%0d.ready", d), 32'(ready[d]), 32'd1);
      checkOutput($sformatf("reset%0d.valid", d), 32'(valid[d]), 32'd0);
      checkOutput($sformatf("reset%0d.data", d),  dout[d], 32'd0);
      checkOutput($sformatf("reset%0d.err", d),   32'(err[d]), 32'd0);
    end
    rst = 1'b0;
    tick;

    loadWord(8'd0, 32'hE400_FFFF);
    doFetch(0, 32'h0, 32'hE400_FFFF, 1'b0, "basic0");
    doFetch(1, 32'h0, 32'hE400_FFFF, 1'b0, "basic1");

    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 1'b1, 32'h0, 1'b0);
      tick;
      for (int i = 0; i < d; i++) tick;
      held = 32'hE400_FFFF;
      for (int c = 0; c < 5; c++) begin
        checkOutput($sformatf("bp%0d.valid%0d", d, c), 32'(valid[d]), 32'd1);
        checkOutput($sformatf("bp%0d.data%0d", d, c),  dout[d], held);
        checkOutput($sformatf("bp%0d.ready%0d", d, c), 32'(ready[d]), 32'd0);
        applyStimulus(d, 1'b1, 32'h4, 1'b0);
        tick;
      end
      applyStimulus(d, 1'b0, 32'h0, 1'b1);
      tick;
      checkOutput($sformatf("bp%0d.release", d), 32'(ready[d]), 32'd1);
      checkOutput($sformatf("bp%0d.cleared", d), 32'(valid[d]), 32'd0);
      tick;
      checkOutput($sformatf("bp%0d.noqueue", d), 32'(valid[d]), 32'd0);
    end

    loadWord(8'd255, 32'h1234_ABCD);
    for (int d = 0; d < 2; d++) begin
      doFetch(d, 32'h0000_03FC, 32'h1234_ABCD, 1'b0, $sformatf("errTop%0d", d));
      doFetch(d, 32'h0000_0006, 32'h0,         1'b1, $sformatf("errMis%0d", d));
      doFetch(d, 32'h0000_03FC, 32'h1234_ABCD, 1'b0, $sformatf("errTop2_%0d", d));
      doFetch(d, 32'h0000_0400, 32'h0,         1'b1, $sformatf("errRange%0d", d));
    end

    loadEn = 1'b1; loadAddr = 8'd3; loadData = 32'hC800_0001;
    doFetch(0, 32'd12, 32'h0, 1'b0, "collOld0");
    loadEn = 1'b0;
    doFetch(0, 32'd12, 32'hC800_0001, 1'b0, "collNew0");
    loadEn = 1'b1; loadAddr = 8'd4; loadData = 32'hC800_0002;
    doFetch(1, 32'd16, 32'h0, 1'b0, "collOld1");
    loadEn = 1'b0;
    doFetch(1, 32'd16, 32'hC800_0002, 1'b0, "collNew1");

    // Reset while instance 1 sits in WAIT; a load during reset must not land.
    applyStimulus(1, 1'b1, 32'h0, 1'b1);
    tick;
    applyStimulus(1, 1'b0, 32'h0, 1'b1);
    rst = 1'b1; loadEn = 1'b1; loadAddr = 8'd5; loadData = 32'hDEAD_BEEF;
    tick;
    rst = 1'b0; loadEn = 1'b0;
    checkOutput("rstWait.valid", 32'(valid[1]), 32'd0);
    checkOutput("rstWait.ready", 32'(ready[1]), 32'd1);
    tick;
    checkOutput("rstWait.stay", 32'(valid[1]), 32'd0);

    for (int d = 0; d < 2; d++) applyStimulus(d, 1'b1, 32'h0, 1'b0);
    tick;
    for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, 32'h0, 1'b0);
    tick;
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("rstHold%0d.pre", d), 32'(valid[d]), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rstHold%0d.valid", d), 32'(valid[d]), 32'd0);
      checkOutput($sformatf("rstHold%0d.ready", d), 32'(ready[d]), 32'd1);
    end
    tick;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rstHold%0d.stay", d), 32'(valid[d]), 32'd0);
      applyStimulus(d, 1'b0, 32'h0, 1'b1);
    end
    for (int d = 0; d < 2; d++) begin
      doFetch(d, 32'h0,  32'hE400_FFFF, 1'b0, $sformatf("rstKeep%0d", d));
      doFetch(d, 32'd20, 32'h0,         1'b0, $sformatf("rstNoLoad%0d", d));
    end

    for (int i = 0; i < 23; i++) loadWord(8'(i), prog[i]);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 23; i++)
        doFetch(d, 32'(4 * i), prog[i], 1'b0, $sformatf("prog%0d.%0d", d, i));
      doFetch(d, 32'd92, 32'h0, 1'b0, $sformatf("prog%0d.noop23", d));
      doFetch(d, 32'd96, 32'h0, 1'b0, $sformatf("prog%0d.noop24", d));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
